// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for one dual-port SRAM port: valid/ready requests in, in-order read responses out.
// Optional power-on clear of the whole array is built when SRAM_CTRL_INIT_EN is defined.
//
// state   | meaning
// ST_INIT | clearing the array, one address per cycle, requests blocked
// ST_RUN  | accepting requests, collecting read data into the response FIFO
module sram_port_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 16,
   parameter int RSP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              sram_we,
   output logic              sram_en,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              init_done
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef SRAM_CTRL_INIT_EN
   localparam state_t START_STATE = ST_INIT;
`else
   localparam state_t START_STATE = ST_RUN;
`endif

   state_t state;
   state_t state_next;

   logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic              inflight;
   logic              push;
   logic              pop;
   logic              accept;
   logic              has_room;
   logic [CNT_W:0]    occupancy;
   logic [DATA_W-1:0] rsp_data_next;

`ifdef SRAM_CTRL_INIT_EN
   logic [ADDR_W-1:0] init_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_addr <= '0;
      end else if (state == ST_INIT) begin
         init_addr <= init_addr + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= START_STATE;
      end else begin
         state <= state_next;
      end
   end

   assign push      = inflight;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_valid = (count != '0);

   // An entry popped this edge frees its slot in time for a new read, which keeps
   // back-to-back reads at one per cycle when the consumer never stalls.
   always_comb begin
      occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
      has_room  = (occupancy < (CNT_W+1)'(RSP_DEPTH));
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      accept     = 1'b0;
      sram_we    = 1'b0;
      sram_en    = 1'b0;
      sram_addr  = req_addr;
      sram_din   = req_wdata;
      case (state)
         ST_INIT: begin
`ifdef SRAM_CTRL_INIT_EN
            sram_we   = ~rst;
            sram_addr = init_addr;
            sram_din  = '0;
            if (init_addr == {ADDR_W{1'b1}}) begin
               state_next = ST_RUN;
            end
`else
            state_next = ST_RUN;
`endif
         end
         ST_RUN: begin
            if (!rst) begin
               req_ready = has_room;
               accept    = req_valid & has_room;
               sram_we   = accept & req_we;
               sram_en   = accept & ~req_we;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

`ifdef SRAM_CTRL_INIT_EN
   assign init_done = (state == ST_RUN);
`else
   assign init_done = 1'b1;
`endif

   always_comb begin
      rd_ptr_next = rd_ptr + PTR_W'(pop);
      count_next  = count + CNT_W'(push) - CNT_W'(pop);
      rsp_data_next = rsp_data;
      if (push && (count == CNT_W'(pop))) begin
         rsp_data_next = sram_dout;
      end else if (count_next != '0) begin
         rsp_data_next = fifo_mem[rd_ptr_next];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= sram_dout;
      end
   end

   // rsp_data is the registered FIFO head; it keeps the last popped word once empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
         rsp_data <= '0;
      end else begin
         count    <= count_next;
         rd_ptr   <= rd_ptr_next;
         wr_ptr   <= wr_ptr + PTR_W'(push);
         inflight <= accept & ~req_we;
         rsp_data <= rsp_data_next;
      end
   end

endmodule
